booth_mult_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one booth_mult8_core_pipelined instance among NUM_REQ requesters.

---
 rtl/booth_mult_pkg.sv | 24 ++
 rtl/booth_rr_arbiter.sv | 45 ++++
 rtl/booth_mult_arbiter.sv | 273 +++++++++++++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_pkg
// Shared constants for the Booth multiplier arbiter slice:
//   - DEFAULT_WIDTH : default operand width of the multiplier core
//   - ST_*          : arbiter FSM state encodings (also visible on dbg_state)
//   - UU/US/SU/SS   : sign_mode encodings, {a_signed, b_signed}
// -----------------------------------------------------------------------------
package booth_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Sign modes: bit 1 = multiplicand signed, bit 0 = multiplier signed
  localparam logic [1:0] UU = 2'b00;
  localparam logic [1:0] US = 2'b01;
  localparam logic [1:0] SU = 2'b10;
  localparam logic [1:0] SS = 2'b11;

endpackage

// File: rtl/booth_rr_arbiter.sv
// -----------------------------------------------------------------------------
// booth_rr_arbiter
// Purely combinational round-robin grant. The winner is the first asserted
// req_valid bit at or above rr_ptr; if none, the search wraps to index 0.
// Ports:
//   req_valid  in  NUM_REQ  request lines
//   rr_ptr     in  ID_W     highest-priority index this round
//   grant      out NUM_REQ  one-hot grant (zero when nothing is valid)
//   grant_idx  out ID_W     binary index of the granted requester
//   grant_any  out 1        some requester is granted
// -----------------------------------------------------------------------------
module booth_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Pass 1: indices at or above the pointer.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i] && (i >= int'(rr_ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    // Pass 2: wrap around; only indices below the pointer can still win here.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mult_arbiter
// Shares one pipelined Booth multiplier core among NUM_REQ requesters with
// round-robin arbitration. One operation is in flight at a time:
//   IDLE -> (grant + accept) -> ISSUE (start pulse) -> WAIT (core done)
//        -> RESP (hold result until consumer accepts) -> IDLE
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The request side holds valid and data until ready;
// req_ready is high only in IDLE and only for the round-robin winner. The
// response side holds resp_valid/resp_id/resp_product/resp_err stable until
// resp_ready is seen high.
//
// Optional feature: define BOOTH_ARB_WATCHDOG_EN to add a WAIT-state
// watchdog. After TIMEOUT_CYCLES cycles in WAIT without mult_done the
// arbiter responds with resp_err=1 and resp_product=0. Without the macro
// WAIT waits indefinitely and resp_err is constant 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester request handshake
//   req_a/req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sign_mode     packed {a_signed,b_signed}, requester i at [i*2 +: 2]
//   resp_*            response handshake, owner ID, product, watchdog flag
//   mult_*            interface to the multiplier core
//   busy              high whenever the FSM is not in IDLE
//   dbg_state         current FSM state (ST_* encodings)
// -----------------------------------------------------------------------------
module booth_mult_arbiter
  import booth_mult_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]   req_sign_mode,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*WIDTH-1:0]     resp_product,
  output logic                   resp_err,
  output logic                   mult_start,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  output logic [1:0]             mult_sign_mode,
  input  logic [2*WIDTH-1:0]     mult_product,
  input  logic                   mult_done,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("booth_mult_arbiter: NUM_REQ must be in 1..8");
  end
  if (ID_W < 1 || (1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("booth_mult_arbiter: ID_W too small for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("booth_mult_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q,   state_d;
  logic [ID_W-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic [1:0]         mode_q,    mode_d;
  logic [ID_W-1:0]    id_q,      id_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;
  logic               wd_expired;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [1:0]         sel_mode;

  booth_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // grant is already qualified by req_valid, so a grant in IDLE is a transfer.
  assign accept = (state_q == ST_IDLE) && grant_any;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_mode = UU;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[i*WIDTH +: WIDTH];
        sel_b    = req_b[i*WIDTH +: WIDTH];
        sel_mode = req_sign_mode[i*2 +: 2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog (optional)
  // ---------------------------------------------------------------------------
`ifdef BOOTH_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q,    err_d;

  // Counter is zeroed in ISSUE so it reads 0 on the first WAIT cycle; expiry
  // fires on the TIMEOUT_CYCLES-th WAIT cycle that has no done.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT && !mult_done) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  assign wd_expired = (state_q == ST_WAIT) && !mult_done &&
                      (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (mult_done) begin
        err_d = 1'b0;
      end else if (wd_expired) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign wd_expired = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mult_done || wd_expired) state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = '0;
    mult_start = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // Ready is combinational from req_valid; masked while reset is held
        // so every output reads 0 during reset.
        req_ready = rst ? '0 : grant;
        busy      = 1'b0;
      end
      ST_ISSUE: mult_start = 1'b1;
      ST_WAIT:  ;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    id_d      = id_q;
    product_d = product_q;

    if (accept) begin
      a_d    = sel_a;
      b_d    = sel_b;
      mode_d = sel_mode;
      id_d   = grant_idx;
      // Next round starts just past the winner, wrapping at NUM_REQ.
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Only WAIT listens to the core; a stray done elsewhere is ignored.
    if (state_q == ST_WAIT) begin
      if (mult_done) begin
        product_d = mult_product;
      end else if (wd_expired) begin
        product_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= UU;
      id_q      <= '0;
      product_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      product_q <= product_d;
    end
  end

  assign mult_a         = a_q;
  assign mult_b         = b_q;
  assign mult_sign_mode = mode_q;
  assign resp_id        = id_q;
  assign resp_product   = product_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
module tb_booth_mult_arbiter;
  import booth_mult_pkg::*;

  localparam int WIDTH          = 8;
  localparam int NUM_REQ        = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 31;
  localparam int EW             = 1 + ID_W + 2*WIDTH;  // {err, id, product}

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_sign_mode;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     resp_err;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_a;
  logic [WIDTH-1:0]         mult_b;
  logic [1:0]               mult_sign_mode;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_done;
  logic                     busy;
  logic [1:0]               dbg_state;

  always #5 clk = ~clk;

  booth_mult_arbiter #(
    .WIDTH          (WIDTH),
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_sign_mode  (req_sign_mode),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_product   (resp_product),
    .resp_err       (resp_err),
    .mult_start     (mult_start),
    .mult_a         (mult_a),
    .mult_b         (mult_b),
    .mult_sign_mode (mult_sign_mode),
    .mult_product   (mult_product),
    .mult_done      (mult_done),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int start_count = 0;
  int rready_mode = 1;      // 0 random, 1 always high, 2 held low
  logic core_suppress = 1'b0;
  logic stray_req = 1'b0;
  int model_ptr = 0;
  logic [WIDTH-1:0] cur_a[NUM_REQ];
  logic [WIDTH-1:0] cur_b[NUM_REQ];
  logic [1:0]       cur_mode[NUM_REQ];

  typedef struct packed {
    logic [1:0]  id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    logic [15:0] prod;
  } vec_t;
  vec_t tab[8];

  // Reference product: extend each operand by its sign flag, multiply, keep 16 bits.
  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] mode);
    longint sa, sb;
    sa = mode[1] ? longint'($signed(a)) : longint'(a);
    sb = mode[0] ? longint'($signed(b)) : longint'(b);
    return 16'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier core model: done 8 cycles after the start pulse is seen
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    logic [15:0] prod;
    cnt = 0;
    prod = '0;
    mult_done = 1'b0;
    mult_product = '0;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (stray_req) begin
        mult_done = 1'b1;
        mult_product = 16'hABCD;
      end else if (mult_start) begin
        cnt = 8;
        prod = ref_mult(mult_a, mult_b, mult_sign_mode);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !core_suppress) begin
          mult_done = 1'b1;
          mult_product = prod;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response driver + scoreboard, grant one-hot monitor, start counter
  // ---------------------------------------------------------------------------
  initial begin
    logic [EW-1:0] e;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mult_start) start_count++;
      if (!rst) check("req_ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
      case (rready_mode)
        0:       resp_ready = 1'($urandom_range(0, 1));
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'b0;
      endcase
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual id=%0d product=%h required none", resp_id, resp_product);
        end else begin
          e = exp_q.pop_front();
          check("resp_err_id_product", 32'({resp_err, resp_id, resp_product}), 32'(e));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: present requests in mask with cur_* data, follow the predicted
  // round-robin order, push expected responses, optionally drain.
  // ---------------------------------------------------------------------------
  task automatic run_round(input logic [NUM_REQ-1:0] mask, input bit wait_drain,
                           input bit use_ovr, input logic [EW-1:0] ovr);
    logic [NUM_REQ-1:0] left, pending, hs;
    int order[$];
    int start0, got, budget, exp_id;
    // Predicted grant order: first pending requester at or after the pointer.
    left = mask;
    while (left != 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (model_ptr + k) % NUM_REQ;
        if (left[idx]) begin
          order.push_back(idx);
          left[idx] = 1'b0;
          model_ptr = (idx + 1) % NUM_REQ;
          break;
        end
      end
    end

    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        req_a[i*WIDTH +: WIDTH] = cur_a[i];
        req_b[i*WIDTH +: WIDTH] = cur_b[i];
        req_sign_mode[i*2 +: 2] = cur_mode[i];
        req_valid[i] = 1'b1;
      end
    end
    pending = mask;
    start0 = start_count;
    got = 0;
    budget = 0;
    while (pending != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
      hs = req_ready & req_valid;
      if (hs != 0) begin
        exp_id = (order.size() != 0) ? order.pop_front() : 0;
        check("grant_onehot", 32'(hs), 32'(NUM_REQ'(1) << exp_id));
        if (use_ovr) exp_q.push_back(ovr);
        else exp_q.push_back({1'b0, ID_W'(exp_id), ref_mult(cur_a[exp_id], cur_b[exp_id], cur_mode[exp_id])});
        @(posedge clk); #1;
        req_valid = req_valid & ~hs;
        pending = pending & ~hs;
        got++;
      end
    end
    if (pending != 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual pending=%b required 0", pending);
      req_valid = req_valid & ~pending;
    end
    if (wait_drain) begin
      budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin
        @(negedge clk);
        budget++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual outstanding=%0d required 0", exp_q.size());
        exp_q.delete();
      end
      check("start_pulse_cycles", 32'(start_count - start0), 32'(got));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_id_prod_err"}, 32'({resp_err, resp_id, resp_product}), 32'd0);
    check({tag, "_mult_start"}, 32'(mult_start), 32'd0);
    check({tag, "_mult_ops"}, 32'({mult_a, mult_b, mult_sign_mode}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Global bound on run time.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int budget, n;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sign_mode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_a[i] = '0;
      cur_b[i] = '0;
      cur_mode[i] = UU;
    end

    tab[0] = '{2'd0, 8'hFD, 8'h05, SS, 16'hFFF1};
    tab[1] = '{2'd2, 8'hFF, 8'hFF, UU, 16'hFE01};
    tab[2] = '{2'd2, 8'hFF, 8'h02, SU, 16'hFFFE};
    tab[3] = '{2'd1, 8'h80, 8'h80, SS, 16'h4000};
    tab[4] = '{2'd3, 8'h80, 8'hFF, SU, 16'h8080};
    tab[5] = '{2'd3, 8'h7F, 8'h81, US, 16'hC0FF};
    tab[6] = '{2'd1, 8'h00, 8'h9C, SS, 16'h0000};
    tab[7] = '{2'd0, 8'h0C, 8'h0A, UU, 16'h0078};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");

    // Requesters 0,1,3 together from pointer 0: order 0,1,3, then again 0,1,3
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cur_a[i] = 8'($urandom);
        cur_b[i] = 8'($urandom);
        cur_mode[i] = 2'($urandom_range(0, 3));
      end
      run_round(4'b1011, 1'b1, 1'b0, '0);
    end

    // Directed vectors
    for (int v = 0; v < 8; v++) begin
      cur_a[tab[v].id] = tab[v].a;
      cur_b[tab[v].id] = tab[v].b;
      cur_mode[tab[v].id] = tab[v].mode;
      run_round(NUM_REQ'(1) << tab[v].id, 1'b1, 1'b1, {1'b0, tab[v].id, tab[v].prod});
    end

    // Back-pressure: resp_ready low for 5 cycles while another requester waits
    rready_mode = 2;
    cur_a[1] = 8'h13;
    cur_b[1] = 8'h07;
    cur_mode[1] = UU;
    run_round(4'b0010, 1'b0, 1'b1, {1'b0, 2'd1, 16'h0085});
    budget = 0;
    while (!resp_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("hold_resp_arrived", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    cur_a[2] = 8'h21;
    cur_b[2] = 8'hF0;
    cur_mode[2] = US;
    req_a[2*WIDTH +: WIDTH] = cur_a[2];
    req_b[2*WIDTH +: WIDTH] = cur_b[2];
    req_sign_mode[2*2 +: 2] = cur_mode[2];
    req_valid[2] = 1'b1;
    n = start_count;
    repeat (5) begin
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_resp_id_prod", 32'({resp_err, resp_id, resp_product}), 32'({1'b0, 2'd1, 16'h0085}));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    check("hold_no_start", 32'(start_count - n), 32'd0);
    rready_mode = 1;
    run_round(4'b0100, 1'b1, 1'b0, '0);

    // Stray done while idle must be ignored
    @(posedge clk); #1;
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_done_resp_valid", 32'(resp_valid), 32'd0);
      check("stray_done_busy", 32'(busy), 32'd0);
    end

    // Reset in the middle of WAIT, then pointer restarts at 0
    cur_a[2] = 8'h5A;
    cur_b[2] = 8'hC3;
    cur_mode[2] = SS;
    run_round(4'b0100, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    check("mid_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_ptr = 0;
    @(negedge clk);
    check_outputs_zero("post_reset");
    cur_a[0] = 8'hF9; cur_b[0] = 8'h0B; cur_mode[0] = SU;
    cur_a[3] = 8'h44; cur_b[3] = 8'h9E; cur_mode[3] = US;
    run_round(4'b1001, 1'b1, 1'b0, '0);

`ifdef BOOTH_ARB_WATCHDOG_EN
    // Core never answers: error response after TIMEOUT_CYCLES cycles in WAIT
    core_suppress = 1'b1;
    cur_a[1] = 8'h05; cur_b[1] = 8'h06; cur_mode[1] = UU;
    run_round(4'b0010, 1'b0, 1'b1, {1'b1, 2'd1, 16'h0000});
    budget = 0;
    while (!mult_start && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("watchdog_latency", 32'(n), 32'(TIMEOUT_CYCLES + 1));
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("watchdog_drained", 32'(exp_q.size()), 32'd0);
    core_suppress = 1'b0;
`endif

    // Randomized rounds against the reference model
    rready_mode = 0;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cur_a[i] = 8'($urandom);
        cur_b[i] = 8'($urandom);
        cur_mode[i] = 2'($urandom_range(0, 3));
      end
      run_round(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'b1, 1'b0, '0);
    end
    rready_mode = 1;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
